// File: rtl/base_addr_table_rd.sv
// base_addr_table_rd
//   Reads a table of NUM_WORDS 32-bit base addresses from a BRAM port.
//   The table starts at START_ADDR, with words ADDR_STRIDE bytes apart.
//   The words are held on base_addr for the downstream signal/DMA blocks.
//   A fetch begins on an accepted start pulse, or once after reset when
//   AUTO_START=1. With POLL_ZERO=1, the fetch repeats while word 0 reads
//   back as zero.
//
// Ports
//   clk, rst_n     : system clock, asynchronous active-low reset
//   start          : single-cycle fetch request (honoured in IDLE/DONE)
//   ram_*          : BRAM controller port (read-only use; ram_clk = clk)
//   base_addr      : captured words, word i at [32*i+31:32*i]
//   busy           : fetch in progress
//   Transfer_Done  : level, set when a fetch completes, cleared by next start
module base_addr_table_rd #(
  parameter logic [31:0] START_ADDR  = 32'h4580_0000,
  parameter int          NUM_WORDS   = 4,
  parameter int          ADDR_STRIDE = 4,
  parameter int          RD_LATENCY  = 1,
  parameter int          AUTO_START  = 1,
  parameter int          POLL_ZERO   = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic                      ram_clk,
  output logic                      ram_rst,
  output logic [31:0]               ram_addr,
  output logic                      ram_en,
  input  logic [31:0]               ram_rd_data,
  output logic [3:0]                ram_we,
  output logic [31:0]               ram_wd_data,
  output logic [NUM_WORDS*32-1:0]   base_addr,
  output logic                      busy,
  output logic                      Transfer_Done
);

  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                                state_q, state_d;
  logic [IDX_W-1:0]                      cnt_q, cnt_d;
  logic [31:0]                           addr_q, addr_d;
  logic                                  en_q, en_d;
  logic                                  busy_q, busy_d;
  logic                                  done_q, done_d;
  logic [1:0]                            auto_q, auto_d;
  logic [NUM_WORDS-1:0][31:0]            base_q, base_d;
  logic [RD_LATENCY-1:0]                 tag_vld_q;
  logic [RD_LATENCY-1:0][IDX_W-1:0]      tag_idx_q;

  logic                                  start_int;
  logic                                  iss_vld;
  logic [IDX_W-1:0]                      iss_idx;
  logic                                  cap;
  logic [IDX_W-1:0]                      cap_idx;
  logic                                  last_cap;
  logic [31:0]                           word0;

  // The tail of the tag pipeline lines up with the data returned for that read.
  assign cap      = tag_vld_q[RD_LATENCY-1];
  assign cap_idx  = tag_idx_q[RD_LATENCY-1];
  assign last_cap = cap && (cap_idx == LAST_IDX);

  // With a single word, word 0 is the one being captured on this same edge.
  assign word0 = (NUM_WORDS == 1) ? ram_rd_data : base_q[0];

  // auto_q counts 0 -> 1 -> 2 after reset release.
  // The internal start fires on the second edge, while auto_q is 1.
  assign start_int = start | ((AUTO_START != 0) && (auto_q == 2'd1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = '0;
    en_d    = 1'b0;
    busy_d  = busy_q;
    done_d  = done_q;
    auto_d  = (auto_q == 2'd2) ? auto_q : auto_q + 2'd1;
    iss_vld = 1'b0;
    iss_idx = cnt_q;
    base_d  = base_q;

    if (cap) begin
      base_d[cap_idx] = ram_rd_data;
    end

    case (state_q)
      IDLE, DONE: begin
        if (start_int) begin
          state_d = ISSUE;
          cnt_d   = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      end
      ISSUE: begin
        en_d    = 1'b1;
        addr_d  = START_ADDR + (32'(cnt_q) * 32'(ADDR_STRIDE));
        iss_vld = 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
      DRAIN: begin
        if (last_cap) begin
          if ((POLL_ZERO == 0) || (word0 != 32'd0)) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      en_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      auto_q    <= 2'd0;
      base_q    <= '0;
      tag_vld_q <= '0;
      tag_idx_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      en_q         <= en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      auto_q       <= auto_d;
      base_q       <= base_d;
      // ---- read-tag pipeline: stage 0 is loaded alongside ram_addr ----
      tag_vld_q[0] <= iss_vld;
      tag_idx_q[0] <= iss_idx;
      for (int i = 1; i < RD_LATENCY; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_idx_q[i] <= tag_idx_q[i-1];
      end
    end
  end

  assign ram_clk       = clk;
  assign ram_rst       = 1'b0;
  assign ram_we        = 4'd0;
  assign ram_wd_data   = 32'd0;
  assign ram_addr      = addr_q;
  assign ram_en        = en_q;
  assign base_addr     = base_q;
  assign busy          = busy_q;
  assign Transfer_Done = done_q;

endmodule

// File: tb/tb_base_addr_table_rd.sv
module tb_base_addr_table_rd;

  localparam logic [31:0] SA = 32'h4580_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1_n, rst_n;
  logic st1, st2, st4, st6;

  // u1: defaults (AUTO_START=1, 4 words, latency 1)
  logic        rclk1, rrst1, en1, busy1, td1;
  logic [31:0] addr1, rd1, wd1;
  logic [3:0]  we1;
  logic [127:0] base1;
  logic [31:0] mem1 [4];
  logic [31:0] off1;
  assign off1 = addr1 - SA;
  assign rd1  = mem1[off1[3:2]];

  // u2: latency 3, 2 words, no auto start
  logic        rclk2, rrst2, en2, busy2, td2;
  logic [31:0] addr2, rd2, wd2, a2_d1, a2_d2, off2;
  logic [3:0]  we2;
  logic [63:0] base2;
  logic [31:0] mem2 [2];
  always @(posedge clk) begin
    a2_d1 <= addr2;
    a2_d2 <= a2_d1;
  end
  assign off2 = a2_d2 - SA;
  assign rd2  = mem2[off2[2]];

  // u4: poll on zero word 0
  logic        rclk4, rrst4, en4, busy4, td4;
  logic [31:0] addr4, rd4, wd4, off4;
  logic [3:0]  we4;
  logic [127:0] base4;
  logic [31:0] mem4 [4];
  assign off4 = addr4 - SA;
  assign rd4  = mem4[off4[3:2]];

  // u6: table straddling the top of the address space
  logic        rclk6, rrst6, en6, busy6, td6;
  logic [31:0] addr6, rd6, wd6;
  logic [3:0]  we6;
  logic [127:0] base6;
  assign rd6 = addr6 ^ 32'h5A5A_0000;

  base_addr_table_rd u1 (
    .clk(clk), .rst_n(rst1_n), .start(st1), .ram_clk(rclk1), .ram_rst(rrst1),
    .ram_addr(addr1), .ram_en(en1), .ram_rd_data(rd1), .ram_we(we1),
    .ram_wd_data(wd1), .base_addr(base1), .busy(busy1), .Transfer_Done(td1));

  base_addr_table_rd #(.NUM_WORDS(2), .RD_LATENCY(3), .AUTO_START(0)) u2 (
    .clk(clk), .rst_n(rst_n), .start(st2), .ram_clk(rclk2), .ram_rst(rrst2),
    .ram_addr(addr2), .ram_en(en2), .ram_rd_data(rd2), .ram_we(we2),
    .ram_wd_data(wd2), .base_addr(base2), .busy(busy2), .Transfer_Done(td2));

  base_addr_table_rd #(.AUTO_START(0), .POLL_ZERO(1)) u4 (
    .clk(clk), .rst_n(rst_n), .start(st4), .ram_clk(rclk4), .ram_rst(rrst4),
    .ram_addr(addr4), .ram_en(en4), .ram_rd_data(rd4), .ram_we(we4),
    .ram_wd_data(wd4), .base_addr(base4), .busy(busy4), .Transfer_Done(td4));

  base_addr_table_rd #(.START_ADDR(32'hFFFF_FFF8), .AUTO_START(0)) u6 (
    .clk(clk), .rst_n(rst_n), .start(st6), .ram_clk(rclk6), .ram_rst(rrst6),
    .ram_addr(addr6), .ram_en(en6), .ram_rd_data(rd6), .ram_we(we6),
    .ram_wd_data(wd6), .base_addr(base6), .busy(busy6), .Transfer_Done(td6));

  int errors = 0;
  int checks = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst1_n = 1'b0; rst_n = 1'b0;
    st1 = 1'b0; st2 = 1'b0; st4 = 1'b0; st6 = 1'b0;
    mem1[0] = 32'h1000; mem1[1] = 32'h2000; mem1[2] = 32'h3000; mem1[3] = 32'h4000;
    tick; tick;
    checks++;
    if (addr1 !== 32'd0 || en1 !== 1'b0) begin
      errors++; $display("FAIL reset_ram: addr=%h en=%b want 0/0", addr1, en1);
    end
    checks++;
    if (base1 !== 128'd0 || busy1 !== 1'b0 || td1 !== 1'b0) begin
      errors++; $display("FAIL reset_out: base=%h busy=%b td=%b want 0", base1, busy1, td1);
    end
    checks++;
    if (we1 !== 4'd0 || wd1 !== 32'd0 || rrst1 !== 1'b0) begin
      errors++; $display("FAIL reset_const: we=%h wd=%h rst=%b want 0", we1, wd1, rrst1);
    end
  endtask

  task automatic test_auto_fetch;
    rst_n = 1'b1; rst1_n = 1'b1;
    tick;
    checks++;
    if (busy1 !== 1'b0) begin
      errors++; $display("FAIL auto_early: busy=%b want 0", busy1);
    end
    tick;  // internal start edge
    checks++;
    if (busy1 !== 1'b1 || td1 !== 1'b0) begin
      errors++; $display("FAIL auto_start: busy=%b td=%b want 1/0", busy1, td1);
    end
    for (int r = 1; r <= 4; r++) begin
      tick;
      checks++;
      if (en1 !== 1'b1 || addr1 !== SA + 32'(4 * (r - 1)) || td1 !== 1'b0) begin
        errors++;
        $display("FAIL auto_addr%0d: en=%b addr=%h td=%b want 1/%h/0", r, en1, addr1, td1,
                 SA + 32'(4 * (r - 1)));
      end
    end
    tick;
    checks++;
    if (td1 !== 1'b1 || busy1 !== 1'b0 || en1 !== 1'b0 || addr1 !== 32'd0) begin
      errors++; $display("FAIL auto_done: td=%b busy=%b en=%b addr=%h want 1/0/0/0",
                         td1, busy1, en1, addr1);
    end
    checks++;
    if (base1 !== {32'h4000, 32'h3000, 32'h2000, 32'h1000}) begin
      errors++; $display("FAIL auto_base: got %h want 4000/3000/2000/1000", base1);
    end
  endtask

  task automatic test_start_ignore;
    int en_cnt, td_rel;
    mem1[0] = 32'h1111_0000; mem1[1] = 32'h1111_0001;
    mem1[2] = 32'h1111_0002; mem1[3] = 32'h1111_0003;
    en_cnt = 0; td_rel = 0;
    st1 = 1'b1; tick; st1 = 1'b0;
    checks++;
    if (td1 !== 1'b0 || busy1 !== 1'b1) begin
      errors++; $display("FAIL ign_accept: td=%b busy=%b want 0/1", td1, busy1);
    end
    for (int r = 1; r <= 8; r++) begin
      if (r == 2) st1 = 1'b1;
      tick;
      st1 = 1'b0;
      if (en1) en_cnt++;
      if (td1 && td_rel == 0) td_rel = r;
    end
    checks++;
    if (en_cnt != 4 || td_rel != 5) begin
      errors++; $display("FAIL ign_single: en_cycles=%0d done_edge=%0d want 4/5", en_cnt, td_rel);
    end
    checks++;
    if (base1 !== {32'h1111_0003, 32'h1111_0002, 32'h1111_0001, 32'h1111_0000}) begin
      errors++; $display("FAIL ign_base: got %h want 1111_000x", base1);
    end
  endtask

  task automatic test_restart_from_done;
    int td_rel;
    td_rel = 0;
    mem1[0] = 32'h2222_0000; mem1[1] = 32'h2222_0001;
    mem1[2] = 32'h2222_0002; mem1[3] = 32'h2222_0003;
    st1 = 1'b1; tick; st1 = 1'b0;
    checks++;
    if (td1 !== 1'b0 || busy1 !== 1'b1) begin
      errors++; $display("FAIL restart_clear: td=%b busy=%b want 0/1", td1, busy1);
    end
    for (int r = 1; r <= 10 && td_rel == 0; r++) begin
      tick;
      if (td1) td_rel = r;
    end
    checks++;
    if (td_rel != 5) begin
      errors++; $display("FAIL restart_done: done_edge=%0d want 5", td_rel);
    end
    checks++;
    if (base1 !== {32'h2222_0003, 32'h2222_0002, 32'h2222_0001, 32'h2222_0000}) begin
      errors++; $display("FAIL restart_base: got %h want 2222_000x", base1);
    end
  endtask

  task automatic test_reset_mid_issue;
    int td_at;
    td_at = 0;
    mem1[0] = 32'h3333_0000; mem1[1] = 32'h3333_0001;
    mem1[2] = 32'h3333_0002; mem1[3] = 32'h3333_0003;
    st1 = 1'b1; tick; st1 = 1'b0;
    tick; tick;
    checks++;
    if (en1 !== 1'b1 || base1[31:0] !== 32'h3333_0000) begin
      errors++; $display("FAIL mid_pre: en=%b word0=%h want 1/33330000", en1, base1[31:0]);
    end
    rst1_n = 1'b0;
    #1;
    checks++;
    if (en1 !== 1'b0 || addr1 !== 32'd0 || base1 !== 128'd0 || busy1 !== 1'b0 || td1 !== 1'b0) begin
      errors++; $display("FAIL mid_reset: en=%b addr=%h base=%h busy=%b td=%b want all 0",
                         en1, addr1, base1, busy1, td1);
    end
    tick; tick;
    rst1_n = 1'b1;
    for (int r = 1; r <= 12 && td_at == 0; r++) begin
      tick;
      if (td1) td_at = r;
    end
    checks++;
    if (td_at != 7) begin
      errors++; $display("FAIL mid_refetch: done_edge=%0d want 7", td_at);
    end
    checks++;
    if (base1 !== {32'h3333_0003, 32'h3333_0002, 32'h3333_0001, 32'h3333_0000}) begin
      errors++; $display("FAIL mid_base: got %h want 3333_000x", base1);
    end
  endtask

  task automatic test_latency3;
    logic        e_en, e_busy, e_td;
    logic [31:0] e_addr;
    mem2[0] = 32'hAAAA_0001; mem2[1] = 32'hBBBB_0002;
    st2 = 1'b1; tick; st2 = 1'b0;
    checks++;
    if (busy2 !== 1'b1 || en2 !== 1'b0) begin
      errors++; $display("FAIL lat_e0: busy=%b en=%b want 1/0", busy2, en2);
    end
    for (int r = 1; r <= 6; r++) begin
      tick;
      e_en   = (r == 1 || r == 2);
      e_busy = (r <= 4);
      e_td   = (r >= 5);
      e_addr = (r == 1) ? SA : ((r == 2) ? SA + 32'd4 : 32'd0);
      checks++;
      if (en2 !== e_en || addr2 !== e_addr || busy2 !== e_busy || td2 !== e_td) begin
        errors++;
        $display("FAIL lat_e%0d: en=%b addr=%h busy=%b td=%b want %b/%h/%b/%b",
                 r, en2, addr2, busy2, td2, e_en, e_addr, e_busy, e_td);
      end
      if (r == 4) begin
        checks++;
        if (base2 !== {32'd0, 32'hAAAA_0001}) begin
          errors++; $display("FAIL lat_cap0: got %h want 0/AAAA0001", base2);
        end
      end
      if (r == 5) begin
        checks++;
        if (base2 !== {32'hBBBB_0002, 32'hAAAA_0001}) begin
          errors++; $display("FAIL lat_cap1: got %h want BBBB0002/AAAA0001", base2);
        end
      end
    end
  endtask

  task automatic test_poll;
    int bursts, td_rel;
    logic busy_ok;
    bursts = 0; td_rel = 0; busy_ok = 1'b1;
    mem4[0] = 32'd0;          mem4[1] = 32'h0011_0001;
    mem4[2] = 32'h0022_0002; mem4[3] = 32'h0033_0003;
    st4 = 1'b1; tick; st4 = 1'b0;
    for (int r = 1; r <= 40 && td_rel == 0; r++) begin
      tick;
      if (en4 && addr4 == SA) begin
        bursts++;
        mem4[0] = (bursts >= 3) ? 32'hABCD_0000 : 32'd0;
      end
      if (td4) td_rel = r;
      else if (!busy4) busy_ok = 1'b0;
    end
    checks++;
    if (bursts != 3 || td_rel != 15) begin
      errors++; $display("FAIL poll_bursts: bursts=%0d done_edge=%0d want 3/15", bursts, td_rel);
    end
    checks++;
    if (busy_ok !== 1'b1 || busy4 !== 1'b0) begin
      errors++; $display("FAIL poll_busy: held=%b end=%b want 1/0", busy_ok, busy4);
    end
    checks++;
    if (base4 !== {32'h0033_0003, 32'h0022_0002, 32'h0011_0001, 32'hABCD_0000}) begin
      errors++; $display("FAIL poll_base: got %h want word0 ABCD0000", base4);
    end
  endtask

  task automatic test_wrap;
    logic [31:0] seen [4];
    logic [31:0] exp6 [4];
    int n, td_rel;
    n = 0; td_rel = 0;
    exp6 = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    seen = '{32'd1, 32'd1, 32'd1, 32'd1};
    st6 = 1'b1; tick; st6 = 1'b0;
    for (int r = 1; r <= 8; r++) begin
      tick;
      if (en6) begin
        if (n < 4) seen[n] = addr6;
        n++;
      end
      if (td6 && td_rel == 0) td_rel = r;
    end
    checks++;
    if (n != 4 || td_rel != 5) begin
      errors++; $display("FAIL wrap_count: addrs=%0d done_edge=%0d want 4/5", n, td_rel);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (seen[k] !== exp6[k]) begin
        errors++; $display("FAIL wrap_addr%0d: got %h want %h", k, seen[k], exp6[k]);
      end
    end
    checks++;
    if (base6 !== {32'h5A5A_0004, 32'h5A5A_0000, 32'hA5A5_FFFC, 32'hA5A5_FFF8}) begin
      errors++; $display("FAIL wrap_base: got %h", base6);
    end
  endtask

  initial begin
    test_reset;
    test_auto_fetch;
    test_start_ignore;
    test_restart_from_done;
    test_reset_mid_issue;
    test_latency3;
    test_poll;
    test_wrap;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/base_addr_table_rd.md
Name: base_addr_table_rd

Overview:
Parametrised BRAM-port reader that fetches a table of NUM_WORDS 32-bit base addresses from a fixed start address and presents them as registered outputs. It replaces single-word base-address fetches that have a fixed-timer done flag. It adds:
- a start handshake and optional auto-start after reset;
- configurable BRAM read latency and address stride;
- an optional poll mode that re-reads the table until word 0 is non-zero.

It sits between the host-written BRAM controller port and the downstream signal/DMA blocks that consume base addresses.

Parameters:
START_ADDR, 32'h4580_0000, byte address of table word 0
NUM_WORDS, 4, words fetched per transfer (1..16)
ADDR_STRIDE, 4, byte increment between consecutive words
RD_LATENCY, 1, cycles from address presentation to valid ram_rd_data (1..3)
AUTO_START, 1, 1 = one internal start one cycle after reset release
POLL_ZERO, 0, 1 = repeat fetch while captured word 0 == 0

Ports:
clk  input  1  system clock; also drives ram_clk
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle request; sampled only in IDLE or DONE
ram_clk  output  1  = clk
ram_rst  output  1  constant 0
ram_addr  output  32  registered read address; 0 when not issuing
ram_en  output  1  registered; 1 only while issuing addresses
ram_rd_data  input  32  BRAM read data
ram_we  output  4  constant 0
ram_wd_data  output  32  constant 0
base_addr  output  NUM_WORDS*32  captured words; word i at bits [32*i+31:32*i]
busy  output  1  high from accepted start until transfer completes
Transfer_Done  output  1  level; high after a complete fetch, held until next accepted start

Behaviour:
- Reset (async, rst_n low):
  - ram_addr = 0, ram_en = 0, base_addr = 0, busy = 0, Transfer_Done = 0.
  - FSM = IDLE; all counters and pipeline tags = 0.
- FSM states:
  - IDLE
  - ISSUE: issue NUM_WORDS reads.
  - DRAIN: wait for outstanding reads.
  - DONE: Transfer_Done = 1.
- Start acceptance:
  - start is accepted when high at an edge while in IDLE or DONE. Edge 0 is that edge.
  - Same edge: Transfer_Done <= 0, busy <= 1, FSM -> ISSUE.
  - start is ignored in ISSUE and DRAIN; there is no queuing.
- AUTO_START=1: an internal start is generated at the second edge after rst_n deasserts, and ORed with start. Generated once per reset.
- ISSUE:
  - At edges 1..NUM_WORDS, ram_en <= 1 and ram_addr <= START_ADDR + k*ADDR_STRIDE, k = 0..NUM_WORDS-1.
  - Address arithmetic is 32-bit modulo 2^32; wrap is permitted and not flagged.
  - After the last address: ram_en <= 0, ram_addr <= 0, FSM -> DRAIN.
- Capture:
  - A RD_LATENCY-deep valid/index shift pipeline tags each issued read.
  - The word for index k is captured into base_addr slot k at edge (k+1)+RD_LATENCY.
  - Slots not yet rewritten keep their previous values.
- Completion:
  - At the edge capturing index NUM_WORDS-1 (edge NUM_WORDS+RD_LATENCY):
    - if POLL_ZERO=0, or the captured word 0 != 0: busy <= 0, Transfer_Done <= 1, FSM -> DONE;
    - else (POLL_ZERO=1 and word 0 == 0): FSM -> ISSUE and the full sequence restarts at the next edge. busy stays 1, Transfer_Done stays 0.
  - Example: NUM_WORDS=1, RD_LATENCY=1 gives Transfer_Done high at edge 2 after the start edge.
- DONE: outputs hold. Transfer_Done stays 1 until the next accepted start.
- Reset mid-transfer: immediately returns to reset values. Captured words are discarded (base_addr = 0).
- ram_we and ram_wd_data are never non-zero.

Test Plan:
1. Defaults, AUTO_START=1, BRAM model (latency 1) holds 0x1000,0x2000,0x3000,0x4000 at 0x4580_0000..0x4580_000C -> ram_addr sequence 0x4580_0000/04/08/0C on 4 consecutive cycles; Transfer_Done rises 5 cycles after the internal start edge; base_addr = {0x4000,0x3000,0x2000,0x1000}.
2. RD_LATENCY=3, NUM_WORDS=2, AUTO_START=0, start pulse at edge 0 -> ram_en high cycles 1-2; captures at edges 4 and 5; Transfer_Done high at edge 5; busy high edges 0..4.
3. start pulsed during ISSUE, and again while DONE -> first pulse ignored (single fetch); second clears Transfer_Done on the same edge and re-fetches, picking up updated BRAM contents.
4. POLL_ZERO=1, word 0 = 0 for the first 2 fetches, then 0xABCD_0000 -> exactly 3 address bursts; busy continuously high; Transfer_Done only after the third; base_addr[31:0] = 0xABCD_0000.
5. rst_n pulsed low mid-ISSUE (after 2 of 4 addresses) -> ram_en, ram_addr, base_addr, busy, Transfer_Done all 0 asynchronously; with AUTO_START=1 a clean fetch restarts after release.
6. START_ADDR=32'hFFFF_FFF8, NUM_WORDS=4 -> addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0, 0x4; completes normally.
